// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues sequential reads to a 1-cycle ROM and
// buffers returned words in a DEPTH-entry FIFO presented to the core with valid/ready.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);
    localparam logic [31:0]   STEP_C  = 32'(PC_STEP);

    logic          rst_n;
    logic [31:0]   pc_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic          inflight_r;
    logic          kill_r;
    logic [31:0]   issued_addr_r;
    logic [31:0]   data_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];

    logic [CW-1:0] credit_s;
    logic [CW-1:0] count_nxt_s;
    logic          empty_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;

    assign rst_n = reset;

    // Credit, issue/push/pop decisions and next occupancy; redirect overrides push and pop
    always_comb begin
        credit_s = count_r + {{PW{1'b0}}, inflight_r};
        empty_s  = (count_r == {CW{1'b0}});
        issue_s  = rst_n && (credit_s < DEPTH_C) && !redirect;
        push_s   = inflight_r && !kill_r && !redirect;
        pop_s    = !empty_s && instr_ready && !redirect;
        if (redirect) begin
            count_nxt_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // PC, pointers, occupancy and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            inflight_r    <= 1'b0;
            kill_r        <= 1'b0;
            issued_addr_r <= 32'h0000_0000;
        end else begin
            count_r    <= count_nxt_s;
            inflight_r <= issue_s;
            kill_r     <= redirect && inflight_r;
            if (issue_s) begin
                issued_addr_r <= pc_r;
            end
            if (redirect) begin
                pc_r     <= {redirect_pc[31:2], 2'b00};
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                if (issue_s) begin
                    pc_r <= pc_r + STEP_C;
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PONE_C;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PONE_C;
                end
            end
        end
    end

    // FIFO storage: returned word paired with the address it was fetched from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem_r[PW'(i)] <= 32'h0000_0000;
                pc_mem_r[PW'(i)]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]   <= issued_addr_r;
        end
    end

    // Core and ROM facing outputs; an empty queue shows an all-zero (NOP) word
    always_comb begin
        imem_req    = issue_s;
        imem_addr   = pc_r;
        instr_valid = !empty_s;
        if (empty_s) begin
            instr    = 32'h0000_0000;
            instr_pc = 32'h0000_0000;
        end else begin
            instr    = data_mem_r[rd_ptr_r];
            instr_pc = pc_mem_r[rd_ptr_r];
        end
    end

    instr_fetch_queue_chk #(
        .CW    (CW),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .count      (count_r),
        .inflight   (inflight_r),
        .kill       (kill_r),
        .instr_valid(instr_valid)
    );
endmodule

// Structural invariants of the fetch queue: credit never exceeds DEPTH.
module instr_fetch_queue_chk #(
    parameter int unsigned CW    = 3,
    parameter int unsigned DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic          inflight,
    input logic          kill,
    input logic          instr_valid
);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, count} + {{CW{1'b0}}, inflight}) <= DEPTH_C);
    a_kill_alone: assert property (@(posedge clk) disable iff (!rst_n)
        kill |-> !inflight);
    a_valid: assert property (@(posedge clk) disable iff (!rst_n)
        instr_valid == (count != {CW{1'b0}}));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized ready/redirect traffic.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    instr_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // reference model: queue of {word, pc}, fetch pc, one pending ROM response
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_addr;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_instr;
    logic [31:0] obs_pc;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0000_0000)      return 32'h0443_0800;
        else if (a == 32'h0000_0004) return 32'h1041_0000;
        else if (a == 32'h0000_0008) return 32'h0841_0000;
        else                         return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = 32'h0000_0000;
        m_pend = 1'b0;
        m_pend_addr = 32'h0;
    endtask

    // entered at a negedge; asserts reset asynchronously and releases it at a later negedge
    task automatic do_reset();
        reset = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // entered at a negedge: drive inputs, compare against model, advance model, go to next negedge
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
        logic exp_req;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = m_pend ? rom(m_pend_addr) : $urandom();
        #1;
        exp_req = ((m_q.size() + (m_pend ? 1 : 0)) < DEPTH) && !rd;
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid;
        obs_instr = instr; obs_pc = instr_pc;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
        chk("instr", instr, (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
        chk("instr_pc", instr_pc, (m_q.size() != 0) ? m_q[0][31:0] : 32'h0);
        if (rd) begin
            m_q.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_pend = 1'b0;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (m_pend) m_q.push_back({rom(m_pend_addr), m_pend_addr});
            if (exp_req) begin
                m_pend      = 1'b1;
                m_pend_addr = m_pc;
                m_pc        = m_pc + 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // sustained stream after reset
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        chk("first_req", 32'(obs_req), 32'h1);
        chk("first_addr", obs_addr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("empty_while_inflight", 32'(obs_valid), 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("stream_add", obs_instr, 32'h0443_0800);
        chk("stream_add_pc", obs_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("stream_sw", obs_instr, 32'h1041_0000);
        chk("stream_sw_pc", obs_pc, 32'h4);
        cycle(1'b1, 1'b0, 32'h0);
        chk("stream_lw", obs_instr, 32'h0841_0000);
        chk("stream_lw_pc", obs_pc, 32'h8);

        // fill with core stalled, then drain
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("full_no_req", 32'(obs_req), 32'h0);
        chk("full_addr", obs_addr, 32'h10);
        chk("full_head_pc", obs_pc, 32'h0);
        chk("model_full_size", 32'(m_q.size()), 32'd4);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("resume_req", 32'(obs_req), 32'h1);
        chk("resume_addr", obs_addr, 32'h10);
        chk("resume_head_pc", obs_pc, 32'h4);
        repeat (12) cycle(1'b1, 1'b0, 32'h0);

        // redirect while PC 8 response is in flight, together with a pop
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0042);
        chk("redir_no_req", 32'(obs_req), 32'h0);
        chk("redir_head_pc", obs_pc, 32'h4);
        chk("model_redir_empty", 32'(m_q.size()), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_req_addr", obs_addr, 32'h40);
        chk("redir_empty", 32'(obs_valid), 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_first_pc", obs_pc, 32'h40);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_second_pc", obs_pc, 32'h44);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // reset with 3 entries queued and a read in flight
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        chk("model_three_pend", 32'({m_q.size() == 3, m_pend}), 32'h3);
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        chk("restart_addr", obs_addr, 32'h0);
        chk("restart_req", 32'(obs_req), 32'h1);

        // pointer wrap with steady flow
        repeat (24) cycle(1'b1, 1'b0, 32'h0);

        // randomized traffic, including redirects near the top of the address space
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h0000_001F);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
